// File: rtl/mips_mc_ctrl_pkg.sv
// Shared opcode, state, ALU-op and PC-select encodings for the multi-cycle MIPS controller.
package mips_mc_ctrl_pkg;

    localparam logic [5:0] OP_R_FORM = 6'h00,
                           OP_J      = 6'h02,
                           OP_BEQ    = 6'h04,
                           OP_ADDI   = 6'h08,
                           OP_LW     = 6'h23,
                           OP_SW     = 6'h2B;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'd0,
                           ALU_SUB   = 2'd1,
                           ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_INC    = 2'd0,
                           PC_BRANCH = 2'd1,
                           PC_JUMP   = 2'd2;

    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_addi;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller-to-datapath/memory bundle; master is the controller side.
interface mips_mc_ctrl_if #(parameter int unsigned CNT_W = 32);

    logic [31:0]      Ins;
    logic             zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             reg_we;
    logic             reg_dst;
    logic             wb_sel;
    logic             ill_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] icount;

    modport master (
        input  Ins, zero, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we,
               alu_src, alu_op, reg_we, reg_dst, wb_sel, ill_op, state, icount
    );

    modport slave (
        output Ins, zero, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we,
               alu_src, alu_op, reg_we, reg_dst, wb_sel, ill_op, state, icount
    );

endinterface

// File: rtl/mips_mc_decode.sv
// Combinational opcode classifier; anything outside the supported set is flagged illegal.
module mips_mc_decode
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (op)
            OP_R_FORM: dec.is_r    = 1'b1;
            OP_J:      dec.is_j    = 1'b1;
            OP_BEQ:    dec.is_beq  = 1'b1;
            OP_ADDI:   dec.is_addi = 1'b1;
            OP_LW:     dec.is_lw   = 1'b1;
            OP_SW:     dec.is_sw   = 1'b1;
            default:   dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) with memory handshakes and a retired-instruction counter.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mips_mc_ctrl_if.master bus
);

    state_t           st;
    dec_t             dec;
    logic [CNT_W-1:0] cnt;

    mips_mc_decode u_decode (
        .op  (bus.Ins[31:26]),
        .dec (dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            case (st)
                FETCH:  if (bus.imem_ack) st <= DECODE;
                DECODE: st <= EXEC;
                EXEC: begin
                    if (dec.is_r || dec.is_addi) begin
                        st <= WB;
                    end else if (dec.is_lw || dec.is_sw) begin
                        st <= MEM;
                    end else begin
                        st <= FETCH;
                        if (dec.is_beq || dec.is_j) cnt <= cnt + CNT_W'(1);
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        if (dec.is_sw) begin
                            st  <= FETCH;
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            st <= WB;
                        end
                    end
                end
                WB: begin
                    st  <= FETCH;
                    cnt <= cnt + CNT_W'(1);
                end
                default: st <= FETCH;
            endcase
        end
    end

    // Strobes depend on same-cycle acks and zero, so they stay combinational; RST masks them all.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_sel   = PC_INC;
        bus.ir_we    = 1'b0;
        bus.alu_src  = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.reg_we   = 1'b0;
        bus.reg_dst  = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.ill_op   = 1'b0;
        if (!RST) begin
            case (st)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                    end
                end
                EXEC: begin
                    bus.alu_src = dec.is_lw || dec.is_sw || dec.is_addi;
                    if (dec.is_r)        bus.alu_op = ALU_FUNCT;
                    else if (dec.is_beq) bus.alu_op = ALU_SUB;
                    if (dec.is_beq) begin
                        bus.pc_we  = bus.zero;
                        bus.pc_sel = PC_BRANCH;
                    end
                    if (dec.is_j) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = PC_JUMP;
                    end
                    bus.ill_op = dec.illegal;
                end
                MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = dec.is_sw;
                    bus.alu_src  = 1'b1;
                end
                WB: begin
                    bus.reg_we  = 1'b1;
                    bus.reg_dst = dec.is_r;
                    bus.wb_sel  = dec.is_lw;
                end
                default: ;
            endcase
        end
    end

    assign bus.state  = st;
    assign bus.icount = cnt;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl, built with a 4-bit counter to exercise wrap.
module tb_mips_mc_ctrl;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_err = 0;
    int   req_cycles;

    mips_mc_ctrl_if #(.CNT_W(4)) bus ();

    mips_mc_ctrl #(.CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive inputs, let combinational outputs settle, then the caller checks.
    task automatic settle();
        #1;
    endtask

    // FETCH with a zero-wait ack, then arrive in DECODE.
    task automatic fetch(input logic [31:0] ins, input string tag);
        bus.Ins      = ins;
        bus.imem_ack = 1'b1;
        settle();
        chk({tag, ".f_state"},  32'(bus.state), 0);
        chk({tag, ".f_ir_we"},  32'(bus.ir_we), 1);
        chk({tag, ".f_pc_we"},  32'(bus.pc_we), 1);
        chk({tag, ".f_pc_sel"}, 32'(bus.pc_sel), 0);
        step();
        bus.imem_ack = 1'b0;
        settle();
        chk({tag, ".d_state"},  32'(bus.state), 1);
        chk({tag, ".d_pc_we"},  32'(bus.pc_we), 0);
        step();
        settle();
        chk({tag, ".e_state"},  32'(bus.state), 2);
    endtask

    initial begin
        RST          = 1'b1;
        bus.Ins      = '0;
        bus.zero     = 1'b0;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b0;
        settle();
        chk("rst_imem_req_masked", 32'(bus.imem_req), 0);
        chk("rst_ir_we_masked",    32'(bus.ir_we), 0);
        step();
        chk("rst_state",  32'(bus.state), 0);
        chk("rst_icount", 32'(bus.icount), 0);
        bus.imem_ack = 1'b0;
        RST          = 1'b0;
        settle();
        chk("idle_imem_req", 32'(bus.imem_req), 1);
        chk("idle_ir_we",    32'(bus.ir_we), 0);

        // FETCH waits for imem_ack with req held high
        step();
        settle();
        chk("fwait_state",    32'(bus.state), 0);
        chk("fwait_imem_req", 32'(bus.imem_req), 1);

        // R-form ADD: 0,1,2,4,0
        fetch(32'h012A4020, "radd");
        chk("radd.e_alu_src", 32'(bus.alu_src), 0);
        chk("radd.e_alu_op",  32'(bus.alu_op), 2);
        step();
        settle();
        chk("radd.w_state",   32'(bus.state), 4);
        chk("radd.w_reg_we",  32'(bus.reg_we), 1);
        chk("radd.w_reg_dst", 32'(bus.reg_dst), 1);
        chk("radd.w_wb_sel",  32'(bus.wb_sel), 0);
        chk("radd.w_icount",  32'(bus.icount), 0);
        step();
        settle();
        chk("radd.end_state",  32'(bus.state), 0);
        chk("radd.end_reg_we", 32'(bus.reg_we), 0);
        chk("radd.end_icount", 32'(bus.icount), 1);

        // LW with dmem_ack on the fourth MEM cycle
        fetch({6'h23, 26'h0123456}, "lw");
        chk("lw.e_alu_src", 32'(bus.alu_src), 1);
        chk("lw.e_alu_op",  32'(bus.alu_op), 0);
        step();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            bus.dmem_ack = (i == 3);
            settle();
            chk("lw.m_state",   32'(bus.state), 3);
            chk("lw.m_dmem_we", 32'(bus.dmem_we), 0);
            chk("lw.m_alu_src", 32'(bus.alu_src), 1);
            req_cycles += int'(bus.dmem_req);
            step();
        end
        bus.dmem_ack = 1'b0;
        settle();
        chk("lw.req_cycles", 32'(req_cycles), 4);
        chk("lw.w_state",    32'(bus.state), 4);
        chk("lw.w_wb_sel",   32'(bus.wb_sel), 1);
        chk("lw.w_reg_dst",  32'(bus.reg_dst), 0);
        chk("lw.w_dmem_req", 32'(bus.dmem_req), 0);
        step();
        settle();
        chk("lw.end_state",  32'(bus.state), 0);
        chk("lw.end_icount", 32'(bus.icount), 2);

        // BEQ taken then not taken
        fetch({6'h04, 26'h0000010}, "beq1");
        bus.zero = 1'b1;
        settle();
        chk("beq1.e_alu_op", 32'(bus.alu_op), 1);
        chk("beq1.e_pc_we",  32'(bus.pc_we), 1);
        chk("beq1.e_pc_sel", 32'(bus.pc_sel), 1);
        step();
        bus.zero = 1'b0;
        settle();
        chk("beq1.end_state",  32'(bus.state), 0);
        chk("beq1.end_icount", 32'(bus.icount), 3);
        fetch({6'h04, 26'h0000010}, "beq0");
        chk("beq0.e_pc_we", 32'(bus.pc_we), 0);
        step();
        settle();
        chk("beq0.end_state",  32'(bus.state), 0);
        chk("beq0.end_icount", 32'(bus.icount), 4);

        // Illegal opcode
        fetch({6'h3F, 26'h0}, "ill");
        chk("ill.e_ill_op", 32'(bus.ill_op), 1);
        chk("ill.e_pc_we",  32'(bus.pc_we), 0);
        step();
        settle();
        chk("ill.end_state",  32'(bus.state), 0);
        chk("ill.end_ill_op", 32'(bus.ill_op), 0);
        chk("ill.end_icount", 32'(bus.icount), 4);

        // SW with ack in the same cycle as req
        fetch({6'h2B, 26'h0}, "sw");
        chk("sw.e_alu_src", 32'(bus.alu_src), 1);
        step();
        bus.dmem_ack = 1'b1;
        settle();
        chk("sw.m_state",    32'(bus.state), 3);
        chk("sw.m_dmem_req", 32'(bus.dmem_req), 1);
        chk("sw.m_dmem_we",  32'(bus.dmem_we), 1);
        step();
        bus.dmem_ack = 1'b0;
        settle();
        chk("sw.end_state",  32'(bus.state), 0);
        chk("sw.end_icount", 32'(bus.icount), 5);

        // Reset in the middle of a MEM wait; a late ack must not matter
        fetch({6'h23, 26'h0}, "rmem");
        step();
        settle();
        chk("rmem.m_state",    32'(bus.state), 3);
        chk("rmem.m_dmem_req", 32'(bus.dmem_req), 1);
        RST = 1'b1;
        settle();
        chk("rmem.rst_dmem_req", 32'(bus.dmem_req), 0);
        step();
        RST          = 1'b0;
        bus.dmem_ack = 1'b1;
        settle();
        chk("rmem.after_state",    32'(bus.state), 0);
        chk("rmem.after_icount",   32'(bus.icount), 0);
        chk("rmem.after_dmem_req", 32'(bus.dmem_req), 0);
        step();
        bus.dmem_ack = 1'b0;
        settle();
        chk("rmem.late_ack_state", 32'(bus.state), 0);

        // 16 jumps wrap the 4-bit counter; stray acks outside FETCH are ignored
        for (int n = 1; n <= 16; n++) begin
            fetch({6'h02, 26'h0000040}, "jmp");
            bus.imem_ack = 1'b1;
            settle();
            chk("jmp.e_pc_we",  32'(bus.pc_we), 1);
            chk("jmp.e_pc_sel", 32'(bus.pc_sel), 2);
            chk("jmp.e_ir_we",  32'(bus.ir_we), 0);
            step();
            bus.imem_ack = 1'b0;
            settle();
            chk("jmp.end_state", 32'(bus.state), 0);
            if (n == 15) chk("jmp.icount_15",  32'(bus.icount), 15);
            if (n == 16) chk("jmp.icount_wrap", 32'(bus.icount), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
